// File: rtl/ccff_loader.sv
// ---------------------------------------------------------------------------
// ccff_loader
//
// Configuration loader feeding the LUT4/16x1-RAM tile chain. Bitstream bytes
// arrive over a valid/ready port and are serialised MSB first onto ccff_head,
// clocked into the chain by a divided prog_clk. A short active-low prog_rst
// pulse clears the chain before each load, and ccff_done rises once all
// NUM_TILES*BITS_PER_TILE bits have been shifted.
//
// Optional feature: define CCFF_CRC_EN to append a CRC-8 check byte
// (poly 0x07, init 0x00, MSB first) after the bitstream. A mismatch ends the
// load in an error state with err high.
//
// Ports:
//   clk        system clock
//   rst        asynchronous active-low reset
//   start      one-cycle pulse, starts a load when not busy
//   s_data     bitstream byte
//   s_valid    s_data valid
//   s_ready    loader accepts a byte this cycle
//   prog_clk   chain shift clock (registered)
//   prog_rst   chain reset, active-low (registered)
//   ccff_head  serial bit into the chain head
//   ccff_done  chain loaded, tiles in normal mode
//   busy       load in progress
//   err        CRC mismatch (constant 0 without CCFF_CRC_EN)
// ---------------------------------------------------------------------------
module ccff_loader #(
    parameter int NUM_TILES     = 1,
    parameter int BITS_PER_TILE = 18,
    parameter int HALF_PERIOD   = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    output logic       s_ready,
    output logic       prog_clk,
    output logic       prog_rst,
    output logic       ccff_head,
    output logic       ccff_done,
    output logic       busy,
    output logic       err
);

    localparam int TOTAL = NUM_TILES * BITS_PER_TILE;
    localparam int GW    = $clog2(TOTAL + 1);
    localparam int HW    = $clog2(HALF_PERIOD + 1);

    localparam logic [GW-1:0] G_TOTAL = GW'(TOTAL);
    localparam logic [GW-1:0] G_ONE   = GW'(1);
    localparam logic [HW-1:0] H_LAST  = HW'(HALF_PERIOD - 1);
    localparam logic [HW-1:0] H_ONE   = HW'(1);

`ifdef CCFF_CRC_EN
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RST_CHAIN = 3'd1,
        ST_FETCH     = 3'd2,
        ST_SHIFT_LO  = 3'd3,
        ST_SHIFT_HI  = 3'd4,
        ST_DONE      = 3'd5,
        ST_CRC_FETCH = 3'd6,
        ST_ERROR     = 3'd7
    } state_t;

    // One CRC-8 (x^8+x^2+x+1) step for a single bit, MSB-first.
    function automatic logic [7:0] crc8_step(input logic [7:0] crc_in, input logic bit_in);
        logic fb;
        fb = crc_in[7] ^ bit_in;
        crc8_step = {crc_in[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    endfunction
`else
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RST_CHAIN = 3'd1,
        ST_FETCH     = 3'd2,
        ST_SHIFT_LO  = 3'd3,
        ST_SHIFT_HI  = 3'd4,
        ST_DONE      = 3'd5
    } state_t;
`endif

    state_t          state;
    logic [7:0]      shreg;     // bit 7 is always the bit currently on ccff_head
    logic [3:0]      bitcnt;    // bits left in this byte; also the 2-cycle chain-reset timer
    logic [GW-1:0]   gcnt;      // bits left in the whole load
    logic [HW-1:0]   hcnt;      // cycles spent in the current prog_clk phase
`ifdef CCFF_CRC_EN
    logic [7:0]      crc;
`else
    assign err = 1'b0;
`endif

    // Loader FSM; all chain-side and handshake outputs are registered here.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            s_ready   <= 1'b0;
            prog_clk  <= 1'b0;
            prog_rst  <= 1'b0;
            ccff_head <= 1'b0;
            ccff_done <= 1'b0;
            busy      <= 1'b0;
            shreg     <= 8'h00;
            bitcnt    <= 4'd0;
            gcnt      <= '0;
            hcnt      <= '0;
`ifdef CCFF_CRC_EN
            crc       <= 8'h00;
            err       <= 1'b0;
`endif
        end else if (start && !busy) begin
            // busy is low exactly in IDLE/DONE/ERROR, the states that honour start
            state     <= ST_RST_CHAIN;
            prog_rst  <= 1'b0;
            ccff_done <= 1'b0;
            busy      <= 1'b1;
            bitcnt    <= 4'd0;
            gcnt      <= G_TOTAL;
            hcnt      <= '0;
`ifdef CCFF_CRC_EN
            crc       <= 8'h00;
            err       <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    prog_rst  <= 1'b1;
                    ccff_head <= 1'b0;
                end
                ST_RST_CHAIN: begin
                    if (bitcnt == 4'd1) begin
                        prog_rst <= 1'b1;
                        s_ready  <= 1'b1;
                        state    <= ST_FETCH;
                    end else begin
                        bitcnt <= bitcnt + 4'd1;
                    end
                end
                ST_FETCH: begin
                    if (s_valid) begin
                        shreg     <= s_data;
                        ccff_head <= s_data[7];
                        // the last byte carries only the remaining bits, top-aligned
                        if (32'(gcnt) >= 32'd8) begin
                            bitcnt <= 4'd8;
                        end else begin
                            bitcnt <= 4'(gcnt);
                        end
                        hcnt      <= '0;
                        s_ready   <= 1'b0;
                        state     <= ST_SHIFT_LO;
                    end else begin
                        s_ready <= 1'b1;
                    end
                end
                ST_SHIFT_LO: begin
                    if (hcnt == H_LAST) begin
                        hcnt     <= '0;
                        prog_clk <= 1'b1;
                        state    <= ST_SHIFT_HI;
                    end else begin
                        hcnt <= hcnt + H_ONE;
                    end
                end
                ST_SHIFT_HI: begin
                    if (hcnt == H_LAST) begin
                        hcnt     <= '0;
                        prog_clk <= 1'b0;
                        shreg    <= {shreg[6:0], 1'b0};
                        bitcnt   <= bitcnt - 4'd1;
                        gcnt     <= gcnt - G_ONE;
`ifdef CCFF_CRC_EN
                        crc      <= crc8_step(crc, shreg[7]);
`endif
                        if (bitcnt != 4'd1) begin
                            ccff_head <= shreg[6];
                            state     <= ST_SHIFT_LO;
                        end else if (gcnt != G_ONE) begin
                            s_ready <= 1'b1;
                            state   <= ST_FETCH;
                        end else begin
`ifdef CCFF_CRC_EN
                            s_ready <= 1'b1;
                            state   <= ST_CRC_FETCH;
`else
                            busy    <= 1'b0;
                            state   <= ST_DONE;
`endif
                        end
                    end else begin
                        hcnt <= hcnt + H_ONE;
                    end
                end
                ST_DONE: begin
                    // rises one cycle after the final prog_clk fall
                    ccff_done <= 1'b1;
                end
`ifdef CCFF_CRC_EN
                ST_CRC_FETCH: begin
                    if (s_valid) begin
                        s_ready <= 1'b0;
                        busy    <= 1'b0;
                        if (s_data == crc) begin
                            state <= ST_DONE;
                        end else begin
                            err   <= 1'b1;
                            state <= ST_ERROR;
                        end
                    end else begin
                        s_ready <= 1'b1;
                    end
                end
                ST_ERROR: begin
                    err       <= 1'b1;
                    ccff_done <= 1'b0;
                end
`endif
                default: begin
                    state    <= ST_IDLE;
                    s_ready  <= 1'b0;
                    prog_clk <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ccff_loader.sv
// ---------------------------------------------------------------------------
// tb_ccff_loader
//
// Randomised scoreboard bench for ccff_loader (3 tiles, 54 bits, 3-cycle
// prog_clk phases). The stimulus side computes the expected bit sequence from
// the bitstream bytes and queues it; a negedge monitor pops one bit per
// prog_clk rise and also checks phase lengths, setup/hold of ccff_head,
// accept-to-rise latency and the last-fall-to-done delay. A tail model of the
// chain is compared at the end of every load.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ccff_loader;

    localparam int NT     = 3;
    localparam int BPT    = 18;
    localparam int HP     = 3;
    localparam int TOTAL  = NT * BPT;
    localparam int NBYTES = (TOTAL + 7) / 8;
`ifdef CCFF_CRC_EN
    localparam int EXTRA_BYTES = 1;
`else
    localparam int EXTRA_BYTES = 0;
`endif

    logic       clk     = 1'b0;
    logic       rst     = 1'b1;
    logic       start   = 1'b0;
    logic [7:0] s_data  = 8'h00;
    logic       s_valid = 1'b0;
    logic       s_ready, prog_clk, prog_rst, ccff_head, ccff_done, busy, err;

    ccff_loader #(
        .NUM_TILES(NT), .BITS_PER_TILE(BPT), .HALF_PERIOD(HP)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .s_data(s_data), .s_valid(s_valid),
        .s_ready(s_ready), .prog_clk(prog_clk), .prog_rst(prog_rst),
        .ccff_head(ccff_head), .ccff_done(ccff_done), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    bit             exp_q[$];
    logic [7:0]     stim [NBYTES];
    logic [TOTAL-1:0] chain     = '0;
    logic [TOTAL-1:0] exp_chain = '0;

    int cyc = 0, rises = 0, acc_cnt = 0, acc_cyc = 0;
    int hi_len = 0, lo_len = 0, head_age = 0, last_fall = 0;
    bit acc_pending = 0, pc_prev = 0, head_prev = 0, done_prev = 0, head_moved = 0;
    bit exp_bit;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: scoreboard pop and chain-side timing checks, sampled on negedge.
    always @(negedge clk) begin
        if (rst) begin
            cyc++;
            if (start && !busy) begin
                rises = 0; acc_cnt = 0; acc_pending = 0;
            end
            if (s_valid && s_ready) begin
                acc_cnt++; acc_cyc = cyc; acc_pending = 1;
            end
            head_age = (ccff_head != head_prev) ? 1 : head_age + 1;
            if (prog_clk && !pc_prev) begin
                if (exp_q.size() == 0) begin
                    check("extra_rise", 1, 0);
                end else begin
                    exp_bit = exp_q.pop_front();
                    check("head_bit", ccff_head, exp_bit);
                end
                chain = {chain[TOTAL-2:0], ccff_head};
                if (acc_pending) check("accept_to_rise", cyc - acc_cyc, HP + 1);
                else             check("low_phase", lo_len, HP);
                check("setup_stable", head_age > HP, 1);
                acc_pending = 0; rises++; hi_len = 1; head_moved = 0;
            end else if (prog_clk) begin
                hi_len++;
                if (ccff_head != head_prev) head_moved = 1;
            end else if (pc_prev) begin
                check("high_phase", hi_len, HP);
                check("hold_stable", head_moved, 0);
                last_fall = cyc; lo_len = 1;
            end else begin
                lo_len++;
            end
`ifndef CCFF_CRC_EN
            if (ccff_done && !done_prev) check("fall_to_done", cyc - last_fall, 1);
`endif
            pc_prev = prog_clk; head_prev = ccff_head; done_prev = ccff_done;
        end else begin
            pc_prev = 0; head_prev = 0; done_prev = 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: bit k of the load is bit (7 - k%8) of byte k/8.
    task automatic prepare();
        logic [7:0] by;
        exp_chain = '0;
        for (int k = 0; k < TOTAL; k++) begin
            by = stim[k / 8];
            exp_q.push_back(by[7 - (k % 8)]);
            exp_chain[TOTAL - 1 - k] = by[7 - (k % 8)];
        end
    endtask

    function automatic logic [7:0] ref_crc();
        logic [7:0] c;
        logic [7:0] by;
        logic       bt;
        c = 8'h00;
        for (int k = 0; k < TOTAL; k++) begin
            by = stim[k / 8];
            bt = by[7 - (k % 8)];
            c = (c[7] ^ bt) ? (8'(c << 1) ^ 8'h07) : 8'(c << 1);
        end
        return c;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        s_data = b; s_valid = 1'b1;
        while (!s_ready && n < 2000) begin tick(); n++; end
        if (!s_ready) check("s_ready_timeout", 0, 1);
        tick();
        s_valid = 1'b0;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!s_ready && n < 2000) begin tick(); n++; end
        if (!s_ready) check("fetch_timeout", 0, 1);
    endtask

    task automatic check_reset_vals();
        check("rst_prog_clk", prog_clk, 0);
        check("rst_prog_rst", prog_rst, 0);
        check("rst_ccff_head", ccff_head, 0);
        check("rst_ccff_done", ccff_done, 0);
        check("rst_s_ready", s_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
    endtask

    // gap_mode: 0 none, 1 ten-cycle stall before byte 2, 2 random stalls.
    task automatic run_load(input int gap_mode, input int crc_mode, input bit poke_start);
        int n;
        int gap;
`ifdef CCFF_CRC_EN
        logic [7:0] c;
`endif
        prepare();
        start = 1'b1; tick(); start = 1'b0;
        check("chain_reset_lo1", prog_rst, 0);
        check("done_cleared", ccff_done, 0);
        check("err_cleared", err, 0);
        tick();
        check("chain_reset_lo2", prog_rst, 0);
        tick();
        check("chain_reset_hi", prog_rst, 1);
        check("fetch_ready", s_ready, 1);
        for (int i = 0; i < NBYTES; i++) begin
            if (gap_mode == 1) gap = (i == 1) ? 10 : 0;
            else if (gap_mode == 2) gap = int'($urandom_range(0, 4));
            else gap = 0;
            if (gap > 0) begin
                wait_ready();
                for (int g = 0; g < gap; g++) begin
                    start = poke_start && (g == 3);
                    tick();
                    start = 1'b0;
                    check("stall_prog_clk", prog_clk, 0);
                    check("stall_ready", s_ready, 1);
                end
            end
            send_byte(stim[i]);
        end
`ifdef CCFF_CRC_EN
        c = ref_crc();
        if (crc_mode != 0) c = c ^ 8'h01;
        send_byte(c);
`endif
        n = 0;
        while (busy && n < 5000) begin tick(); n++; end
        check("load_timeout", busy, 0);
        tick();
        check("rise_count", rises, TOTAL);
        check("bytes_accepted", acc_cnt, NBYTES + EXTRA_BYTES);
        check("queue_drained", exp_q.size(), 0);
        check("chain_content", chain, exp_chain);
        check("done_level", ccff_done, (crc_mode == 0) ? 1 : 0);
        check("err_level", err, (crc_mode != 0) ? 1 : 0);
        check("idle_ready", s_ready, 0);
        check("idle_prog_rst", prog_rst, 1);
        exp_q.delete();
    endtask

    initial begin
        #2 rst = 1'b0;
        #1 check_reset_vals();
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        check("prog_rst_before_edge", prog_rst, 0);
        tick();
        check("prog_rst_after_edge", prog_rst, 1);
        check("idle_busy", busy, 0);

        // directed pattern with a stalled byte and a start pulse while busy
        stim[0] = 8'hA5; stim[1] = 8'h3C; stim[2] = 8'hC0; stim[3] = 8'hFF;
        stim[4] = 8'h00; stim[5] = 8'h5A; stim[6] = 8'hFF;
        run_load(1, 0, 1'b1);

        for (int l = 0; l < 4; l++) begin
            for (int i = 0; i < NBYTES; i++) stim[i] = 8'($urandom);
            run_load(2, 0, l[0]);
        end

        // reset in the middle of a load
        for (int i = 0; i < NBYTES; i++) stim[i] = 8'($urandom);
        prepare();
        start = 1'b1; tick(); start = 1'b0;
        send_byte(stim[0]);
        send_byte(stim[1]);
        repeat (5) tick();
        #2 rst = 1'b0;
        #1 check_reset_vals();
        exp_q.delete();
        tick();
        #2 rst = 1'b1;
        check("prog_rst_held", prog_rst, 0);
        tick();
        check("prog_rst_release", prog_rst, 1);
        check("post_reset_busy", busy, 0);

        for (int i = 0; i < NBYTES; i++) stim[i] = 8'($urandom);
        run_load(2, 0, 1'b0);

`ifdef CCFF_CRC_EN
        for (int i = 0; i < NBYTES; i++) stim[i] = 8'h00;
        run_load(0, 0, 1'b0);
        run_load(0, 1, 1'b0);
        for (int i = 0; i < NBYTES; i++) stim[i] = 8'($urandom);
        run_load(2, 0, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

endmodule

// File: doc/ccff_loader.md
# ccff_loader

Configuration loader that sits directly upstream of the LUT4/16x1-RAM tile chain. It accepts a configuration bitstream as bytes over a valid/ready interface and generates the chain-side signals: a slow `prog_clk`, the serial `ccff_head` bit, a chain reset pulse on `prog_rst`, and the final `ccff_done` level. After `ccff_done` rises, the tiles leave shift mode and operate as LUT or RAM.

## Interface
Parameters:
- `NUM_TILES`, default 1: number of tiles daisy-chained tail-to-head.
- `BITS_PER_TILE`, default 18: configuration bits per tile.
- `HALF_PERIOD`, default 1: `clk` cycles per `prog_clk` phase, range 1..255.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous, active-low.
- `start` in 1: one-cycle pulse that begins a load; ignored unless state is IDLE, DONE or ERROR.
- `s_data` in 8: bitstream byte.
- `s_valid` in 1: `s_data` valid.
- `s_ready` out 1: loader accepts a byte this cycle.
- `prog_clk` out 1: configuration chain clock, registered.
- `prog_rst` out 1: chain reset, active-low, registered.
- `ccff_head` out 1: serial configuration bit into the chain head.
- `ccff_done` out 1: high means the chain is loaded and in normal mode.
- `busy` out 1: high in any state other than IDLE, DONE or ERROR.
- `err` out 1: CRC mismatch. Exists only with `CCFF_CRC_EN`, otherwise tied 0.

## Operation
- `TOTAL = NUM_TILES*BITS_PER_TILE`. `NBYTES = ceil(TOTAL/8)`.
- Bit order:
  - Each byte is shifted MSB first.
  - In the final byte, only the top `TOTAL mod 8` bits are shifted; the rest are discarded. If the remainder is 0, all 8 are shifted.
  - The first bit shifted ends in the chain position farthest from the head.
- States:
  - IDLE → RST_CHAIN on `start`.
  - RST_CHAIN: `prog_rst`=0 for 2 cycles, then FETCH. `ccff_done` is cleared on entry.
  - FETCH: `s_ready`=1. On `s_valid`: latch the byte into the shift register, load the bit count (8, or the remainder for the last byte), go to SHIFT_LO.
  - SHIFT_LO: `ccff_head` is driven with the current bit and `prog_clk`=0 for `HALF_PERIOD` cycles → SHIFT_HI.
  - SHIFT_HI: `prog_clk`=1 for `HALF_PERIOD` cycles. On exit, decrement the bit counter and the global counter, then:
    - more bits in the byte → SHIFT_LO;
    - else global count > 0 → FETCH;
    - else → DONE, or CRC_FETCH when `CCFF_CRC_EN` is defined.
  - DONE: `ccff_done`=1, held until the next `start`.
  - ERROR: `err`=1, `ccff_done`=0, held until the next `start`.
- `s_ready` is 0 in every state except FETCH and CRC_FETCH. There is a single byte buffer and no skid.
- Between bits, `ccff_head` holds its last value. It is 0 in IDLE.
- A `start` while `busy` is ignored; the load in progress continues.
- Counters are sized as `$clog2(TOTAL+1)` bits and `$clog2(HALF_PERIOD+1)` bits. No wrap is possible.

## Timing
Reset values, forced asynchronously whenever `rst`=0:
- `prog_clk`=0, `prog_rst`=0, `ccff_head`=0, `ccff_done`=0, `s_ready`=0, `busy`=0, `err`=0, state IDLE.
- `prog_rst` goes to 1 on the first `clk` edge after `rst` deasserts.

Per-bit and end-to-end timing:
- Each bit takes exactly `2*HALF_PERIOD` cycles.
- `ccff_head` is stable for `HALF_PERIOD` cycles before each `prog_clk` rising edge and for `HALF_PERIOD` cycles after it.
- `prog_clk` produces exactly `TOTAL` rising edges per load.
- Byte accept → first `prog_clk` rise: `HALF_PERIOD`+1 cycles.
- Final `prog_clk` fall → `ccff_done`=1: 1 cycle (without CRC).

Reset and error cases:
- Reset mid-load aborts the load. Outputs go to their reset values; the chain contents are undefined and a new `start` is required.
- `s_valid` may stall FETCH indefinitely. `prog_clk` stays 0 during the stall.

## Configuration
- Macro `CCFF_CRC_EN`.
- Defined:
  - A CRC-8 (poly 0x07, init 0x00, MSB-first, no reflection, no final XOR) is accumulated over the `TOTAL` shifted bits, in shift order only. Padding bits are excluded.
  - After the last bit, state CRC_FETCH accepts one more byte with no `prog_clk` activity. If it equals the CRC → DONE; otherwise → ERROR.
- Undefined: CRC logic, the CRC_FETCH state and the ERROR state are absent, and `err` is a constant 0.

## Test plan
- Reset: hold `rst`=0 mid-load with `HALF_PERIOD`=1 → all outputs at reset values; after release and `start`, a full load completes normally.
- Basic load (`NUM_TILES`=1, `HALF_PERIOD`=1, bytes 0xA5, 0x3C, 0xC0) → 18 `prog_clk` rises; `ccff_head` sampled at each rise reads 1010_0101_0011_1100_11; `ccff_done`=1 one cycle after the last fall; chain tail model holds the expected bits.
- Divider (`HALF_PERIOD`=3) → each `prog_clk` phase lasts exactly 3 cycles; `ccff_head` never changes within 3 cycles of a rising edge.
- Backpressure: `s_valid` withheld for 10 cycles between bytes 1 and 2 → `prog_clk` stays 0 during the gap; sampled data is unchanged; `start` pulsed while `busy` has no effect.
- Multi-tile (`NUM_TILES`=3, TOTAL 54) → 7 bytes accepted, 54 rises, top 6 bits of byte 7 used.
- CRC (`CCFF_CRC_EN`): all-zero bitstream + CRC byte 0x00 → DONE with `err`=0; CRC byte 0x01 → ERROR with `err`=1 and `ccff_done`=0; a new `start` clears `err`.
